sr_latch_driver: RTL and testbench

Upstream drive stage for `SR_LATCH`. The block takes two raw, asynchronous, bouncy set/reset request inputs, such as pushbuttons, and synchronizes and debounces them. It then issues clean, registered, mutually exclusive pulses on `s_out`/`r_out` that feed the latch's S and R inputs. It never presents S=R=1 to the latch; that invalid combination is reported on `conflict` instead.

---
 rtl/sr_ctrl_pkg.sv | 26 ++
 rtl/sr_debounce.sv | 48 ++++
 rtl/sr_latch_driver.sv | 131 +++++++++++++
 tb/tb_sr_latch_driver.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared types and sizing helpers for the SR latch drive stage.
package sr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SET,
        ST_RST,
        ST_GAP,
        ST_CONFLICT
    } state_t;

    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_SET,
        PEND_RST
    } pend_t;

    localparam int SYNC_DEPTH = 2;

    // Width of a counter that must be able to hold the value `count`.
    function automatic int cnt_width(input int count);
        return $clog2(count + 1);
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// Synchronizer, stability counter and rising-edge detector for one raw request.
module sr_debounce
    import sr_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic rise
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_DEPTH-1:0] sync;
    logic                  synced;
    logic [CNT_W-1:0]      cnt;
    logic                  db_d;

    assign synced = sync[SYNC_DEPTH-1];

    // NOTE: every register here is written with <= so all flops update from
    // the same pre-edge values; blocking writes would chain the sync stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            db   <= 1'b0;
            db_d <= 1'b0;
        end else begin
            sync <= {sync[SYNC_DEPTH-2:0], raw};
            db_d <= db;
            if (synced == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= synced;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = db & ~db_d;

endmodule

// File: rtl/sr_latch_driver.sv
// Debounced set/reset requests turned into clean, mutually exclusive latch pulses.
module sr_latch_driver
    import sr_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2,
    parameter int RESET_PULSE     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic s_raw,
    input  logic r_raw,
    output logic s_out,
    output logic r_out,
    output logic conflict,
    output logic busy
);

    localparam int PCNT_W = cnt_width(PULSE_CYCLES);
    localparam logic [PCNT_W-1:0] PCNT_FULL = PCNT_W'(PULSE_CYCLES);
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);
    localparam state_t ST_AFTER_RST = (RESET_PULSE != 0) ? ST_INIT : ST_IDLE;

    logic s_db, s_rise, r_db, r_rise;

    state_t             state, state_n;
    pend_t              pend, pend_n;
    logic [PCNT_W-1:0]  pcnt, pcnt_n;
    logic               s_n, r_n;
    logic               go_set, go_rst;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_s_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (s_raw),
        .db   (s_db),
        .rise (s_rise)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_r_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (r_raw),
        .db   (r_db),
        .rise (r_rise)
    );

    // A stored request outranks a fresh edge seen in IDLE.
    assign go_set = (pend == PEND_SET) || (pend == PEND_NONE && s_rise);
    assign go_rst = (pend == PEND_RST) || (pend == PEND_NONE && !s_rise && r_rise);

    // NOTE: every output of this block gets a default before any branch;
    // a path that skipped one would infer a latch.
    always_comb begin
        state_n = state;
        pend_n  = pend;
        pcnt_n  = pcnt;
        s_n     = 1'b0;
        r_n     = 1'b0;

        if (state != ST_CONFLICT && s_db && r_db) begin
            state_n = ST_CONFLICT;
            pend_n  = PEND_NONE;
            pcnt_n  = '0;
        end else begin
            if (state inside {ST_INIT, ST_SET, ST_RST, ST_GAP}) begin
                if (s_rise)      pend_n = PEND_SET;
                else if (r_rise) pend_n = PEND_RST;
            end

            case (state)
                ST_IDLE: begin
                    if (go_set) begin
                        state_n = ST_SET;
                        pend_n  = PEND_NONE;
                        pcnt_n  = PCNT_ONE;
                        s_n     = 1'b1;
                    end else if (go_rst) begin
                        state_n = ST_RST;
                        pend_n  = PEND_NONE;
                        pcnt_n  = PCNT_ONE;
                        r_n     = 1'b1;
                    end
                end
                ST_SET: begin
                    if (pcnt == PCNT_FULL) begin
                        state_n = ST_GAP;
                        pcnt_n  = '0;
                    end else begin
                        pcnt_n = pcnt + 1'b1;
                        s_n    = 1'b1;
                    end
                end
                ST_INIT, ST_RST: begin
                    if (pcnt == PCNT_FULL) begin
                        state_n = ST_GAP;
                        pcnt_n  = '0;
                    end else begin
                        pcnt_n = pcnt + 1'b1;
                        r_n    = 1'b1;
                    end
                end
                ST_GAP:      state_n = ST_IDLE;
                ST_CONFLICT: if (!s_db && !r_db) state_n = ST_IDLE;
                default:     state_n = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_AFTER_RST;
            pend     <= PEND_NONE;
            pcnt     <= '0;
            s_out    <= 1'b0;
            r_out    <= 1'b0;
            conflict <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            pend     <= pend_n;
            pcnt     <= pcnt_n;
            s_out    <= s_n;
            r_out    <= r_n;
            conflict <= (state_n == ST_CONFLICT);
            busy     <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Randomized and directed stimulus for two driver configurations against a behavioural model.
module tb_sr_latch_driver;

    localparam int D   = 4;
    localparam int P_A = 2;
    localparam int P_B = 6;

    localparam int M_INIT = 0, M_IDLE = 1, M_S = 2, M_R = 3, M_GAP = 4, M_CONF = 5;

    logic clk = 1'b0;
    logic rst, s_raw, r_raw;
    logic s_out_a, r_out_a, conflict_a, busy_a;
    logic s_out_b, r_out_b, conflict_b, busy_b;

    always #5 clk = ~clk;

    sr_latch_driver #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P_A), .RESET_PULSE(1)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .s_raw    (s_raw),
        .r_raw    (r_raw),
        .s_out    (s_out_a),
        .r_out    (r_out_a),
        .conflict (conflict_a),
        .busy     (busy_a)
    );

    sr_latch_driver #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P_B), .RESET_PULSE(0)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .s_raw    (s_raw),
        .r_raw    (r_raw),
        .s_out    (s_out_b),
        .r_out    (r_out_b),
        .conflict (conflict_b),
        .busy     (busy_b)
    );

    // Reference model: raw-sample history windows and a per-instance mode/countdown.
    int   plen[2]   = '{P_A, P_B};
    int   rpulse[2] = '{1, 0};
    int   mode[2], left[2], pend[2];
    logic es[2], er[2], ec[2], eb[2];
    logic [D:0] hs_s, hs_r;
    logic db_s, db_r, dbd_s, dbd_r;
    logic q_a;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, $signed(got), $signed(exp), cyc);
        end
    endtask

    // A debounced level flips once the D samples preceding the newest all disagree with it.
    function automatic logic db_next(input logic cur, input logic [D:0] hist);
        logic [D-1:0] win;
        win = hist[D:1];
        return cur ? |win : &win;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mode[i] = (rpulse[i] != 0) ? M_INIT : M_IDLE;
            left[i] = plen[i];
            pend[i] = 0;
            es[i] = 1'b0; er[i] = 1'b0; ec[i] = 1'b0; eb[i] = 1'b0;
        end
        hs_s = '0; hs_r = '0;
        db_s = 1'b0; db_r = 1'b0; dbd_s = 1'b0; dbd_r = 1'b0;
    endtask

    task automatic start_pulse(input int i, input int m);
        mode[i] = m;
        left[i] = plen[i] - 1;
        pend[i] = 0;
    endtask

    task automatic fsm_step(input int i, input logic rise_s, input logic rise_r);
        if (mode[i] != M_CONF && db_s && db_r) begin
            mode[i] = M_CONF;
            pend[i] = 0;
        end else begin
            if (mode[i] != M_IDLE && mode[i] != M_CONF) begin
                if (rise_s)      pend[i] = 1;
                else if (rise_r) pend[i] = 2;
            end
            case (mode[i])
                M_IDLE: begin
                    if (pend[i] == 1)      start_pulse(i, M_S);
                    else if (pend[i] == 2) start_pulse(i, M_R);
                    else if (rise_s)       start_pulse(i, M_S);
                    else if (rise_r)       start_pulse(i, M_R);
                end
                M_S, M_R, M_INIT: begin
                    if (left[i] == 0) mode[i] = M_GAP;
                    else              left[i] = left[i] - 1;
                end
                M_GAP:  mode[i] = M_IDLE;
                M_CONF: if (!db_s && !db_r) mode[i] = M_IDLE;
                default: ;
            endcase
        end
        es[i] = (mode[i] == M_S);
        er[i] = (mode[i] == M_R) || (mode[i] == M_INIT);
        ec[i] = (mode[i] == M_CONF);
        eb[i] = (mode[i] != M_IDLE);
    endtask

    task automatic model_step(input logic s_v, input logic r_v);
        logic rise_s, rise_r;
        rise_s = db_s & ~dbd_s;
        rise_r = db_r & ~dbd_r;
        for (int i = 0; i < 2; i++) fsm_step(i, rise_s, rise_r);
        dbd_s = db_s;
        dbd_r = db_r;
        db_s  = db_next(db_s, hs_s);
        db_r  = db_next(db_r, hs_r);
        hs_s  = {hs_s[D-1:0], s_v};
        hs_r  = {hs_r[D-1:0], r_v};
    endtask

    task automatic compare_all();
        check("a.s_out",    s_out_a,    es[0]);
        check("a.r_out",    r_out_a,    er[0]);
        check("a.conflict", conflict_a, ec[0]);
        check("a.busy",     busy_a,     eb[0]);
        check("b.s_out",    s_out_b,    es[1]);
        check("b.r_out",    r_out_b,    er[1]);
        check("b.conflict", conflict_b, ec[1]);
        check("b.busy",     busy_b,     eb[1]);
        check("a.exclusive", s_out_a & r_out_a, 0);
        check("b.exclusive", s_out_b & r_out_b, 0);
    endtask

    // One clock: apply inputs at the falling edge, advance the model at the rising edge, compare after.
    task automatic cycle(input logic s_v, input logic r_v, input logic rst_v);
        s_raw = s_v;
        r_raw = r_v;
        rst   = rst_v;
        @(posedge clk);
        if (rst_v) model_reset();
        else       model_step(s_v, r_v);
        @(negedge clk);
        cyc++;
        compare_all();
        if (s_out_a)      q_a = 1'b1;
        else if (r_out_a) q_a = 1'b0;
    endtask

    initial begin
        int   cnt, db_seen, first, fs, fr, k;
        logic found, s_l, r_l, s_v, r_v, rst_v;
        int   len;

        rst = 1'b1; s_raw = 1'b0; r_raw = 1'b0; q_a = 1'b1;
        model_reset();
        @(negedge clk);
        repeat (3) cycle(1'b0, 1'b0, 1'b1);

        // Power-up reset pulse on instance A; instance B starts idle.
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (r_out_a) cnt++;
        end
        check("init.r_cycles", cnt, 2);
        check("init.q", q_a, 0);
        check("init.busy_a", busy_a, 0);
        check("init.busy_b", busy_b, 0);

        // Set latency, then a reset press.
        first = -1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (s_out_a && first < 0) first = i;
        end
        check("set.latency", first, 6);
        check("set.q", q_a, 1);
        repeat (10) cycle(1'b0, 1'b0, 1'b0);
        repeat (14) cycle(1'b0, 1'b1, 1'b0);
        check("rst.q", q_a, 0);
        repeat (10) cycle(1'b0, 1'b0, 1'b0);

        // Bounce shorter than the debounce window.
        cnt = 0; db_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(((i >> 1) & 1) == 0, 1'b0, 1'b0);
            if (s_out_a) cnt++;
            if (dut_a.s_db) db_seen++;
        end
        check("bounce.pulses", cnt, 0);
        check("bounce.db", db_seen, 0);
        repeat (8) cycle(1'b0, 1'b0, 1'b0);

        // Conflict entry, hold while s stays high, exit with no pulse.
        repeat (12) cycle(1'b1, 1'b0, 1'b0);
        repeat (10) cycle(1'b1, 1'b1, 1'b0);
        check("conf.rise", conflict_a, 1);
        check("conf.outs", s_out_a | r_out_a, 0);
        repeat (8) cycle(1'b1, 1'b0, 1'b0);
        check("conf.hold", conflict_a, 1);
        cnt = 0;
        repeat (12) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (s_out_a || r_out_a) cnt++;
        end
        check("conf.no_pulse", cnt, 0);
        check("conf.fall", conflict_a, 0);
        check("conf.busy", busy_a, 0);

        // Reset request arriving during a long set pulse is held and serviced.
        fs = -1; fr = -1;
        for (int i = 0; i < 30; i++) begin
            cycle(i < 4, i >= 4, 1'b0);
            if (s_out_b && fs < 0) fs = i;
            if (r_out_b && fr < 0) fr = i;
        end
        check("pend.s_edge", fs, 6);
        check("pend.spacing", fr - fs, P_B + 2);
        repeat (16) cycle(1'b0, 1'b0, 1'b0);

        // Reset asserted mid-pulse.
        found = 1'b0; k = 0;
        while (!found && k < 20) begin
            cycle(1'b1, 1'b0, 1'b0);
            found = s_out_a;
            k++;
        end
        check("mid.pulse_seen", found, 1);
        cycle(1'b1, 1'b0, 1'b1);
        check("mid.s_out", s_out_a, 0);
        check("mid.r_out", r_out_a, 0);
        check("mid.busy", busy_a, 0);
        repeat (20) cycle(1'b1, 1'b0, 1'b0);
        repeat (12) cycle(1'b0, 1'b0, 1'b0);

        // Randomized held levels with occasional bounces and resets.
        repeat (60) begin
            s_l = 1'($urandom_range(0, 1));
            r_l = 1'(($urandom % 4) == 0);
            len = int'($urandom_range(1, 12));
            for (int j = 0; j < len; j++) begin
                s_v   = s_l ^ 1'(($urandom % 8) == 0);
                r_v   = r_l ^ 1'(($urandom % 8) == 0);
                rst_v = 1'(($urandom % 80) == 0);
                cycle(s_v, r_v, rst_v);
            end
        end
        repeat (16) cycle(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
